// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter with a small push-side FIFO.
// Bytes pushed on tx_data/tx_push are queued, then shifted out LSB first
// as start bit, 8 data bits and stop bit, each lasting BAUD_DIV clocks.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (tx low)
// DATA  | data bits, LSB first, bit_idx selects the current bit
// STOP  | stop bit (tx high), tx_done pulses on its last cycle
module uart_tx_fifo #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int ADDR_W   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_push,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(BAUD_DIV - 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   FIFO_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q;
    logic              push_ok, pop;

    // Transmit FSM registers
    state_t            state_q;
    logic [CNT_W-1:0]  baud_cnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q, busy_q, done_q;

    // Registered full flag gates the push, so a push while full is dropped
    // even when a pop happens in the same cycle.
    assign push_ok = tx_push && !full_q;
    assign pop     = (state_q == IDLE) && !empty_q;

    // Next pointer and occupancy values from this cycle's push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_d + FIFO_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_d - FIFO_ONE;
        end
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
        end
    end

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // Transmit FSM with baud counter; all outputs registered alongside state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty_q) begin
                        shift_q    <= mem_q[rd_ptr_q];
                        state_q    <= START;
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt_q == CNT_LAST) begin
                        state_q    <= DATA;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (baud_cnt_q == CNT_LAST) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (baud_cnt_q == CNT_LAST) begin
                        state_q    <= IDLE;
                        baud_cnt_q <= '0;
                        busy_q     <= 1'b0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                        // Raise done one edge early so it lines up with the
                        // final stop-bit cycle.
                        if (baud_cnt_q == CNT_PRE) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_full  = full_q;
    assign tx_empty = empty_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign tx       = tx_q;

endmodule
